rf_writeback_ctrl: RTL and testbench
====================================

Name: rf_writeback_ctrl

Overview:
Write-port controller for the 8x32 register file. Two writeback sources compete for the file's single write port:
- ALU result channel (32-bit data).
- Immediate-load channel (8-bit data, zero-extended).

The block round-robin arbitrates between them and drives the file's WE3/A3/WD3 from registers. It also keeps a per-register pending scoreboard so the issue stage can stall on read-after-write hazards against RD1/RD2 sources.

Parameters:
- NREGS, 8, number of architectural registers.
- AW, 3, register address width; NREGS must equal 2**AW.
- DW, 32, register data width.
- IW, 8, immediate-channel data width; IW <= DW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- alu_req  in  1  ALU writeback request; held until granted.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_gnt  out  1  combinational grant to ALU channel.
- imm_req  in  1  immediate writeback request; held until granted.
- imm_addr  in  AW  immediate destination register.
- imm_data  in  IW  immediate value.
- imm_gnt  out  1  combinational grant to immediate channel.
- rsv_valid  in  1  issue stage reserves a destination this cycle.
- rsv_addr  in  AW  reserved destination.
- rd_a1  in  AW  source address 1 of the instruction in issue.
- rd_a2  in  AW  source address 2 of the instruction in issue.
- hazard  out  1  combinational; 1 when either source is pending.
- rf_we  out  1  registered write enable to register file.
- rf_a3  out  AW  registered write address.
- rf_wd  out  DW  registered write data.
- pending  out  NREGS  scoreboard bits, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_a3=0, rf_wd=0, pending=0.
  - Priority pointer last=IMM, so the ALU wins the first conflict.
  - alu_gnt/imm_gnt follow the combinational rules below, so they are 0 while req=0.
- Arbitration (combinational, cycle n):
  - Exactly one grant when any req is high.
  - Single requester: granted.
  - Both requesting: grant the channel not recorded in last. last updates to the granted channel at the edge ending cycle n; it is unchanged when there is no grant.
  - A requester not granted keeps req and data stable; it is granted in cycle n+1 at the latest (the two-channel round-robin bound).
- Write launch:
  - Grant in cycle n produces rf_we=1 in cycle n+1, with rf_a3 = granted addr.
  - rf_wd = ALU data, or imm_data zero-extended to DW.
  - No grant in cycle n: rf_we=0 in cycle n+1; rf_a3/rf_wd hold their previous values.
  - The register file commits the write at the end of cycle n+1.
- Register 0:
  - A granted request with addr=0 is consumed: grant asserted and last updated.
  - rf_we stays 0 and pending is unchanged.
  - Reservations of address 0 are ignored.
- Scoreboard:
  - pending[rsv_addr] is set at the edge ending a cycle with rsv_valid=1 and rsv_addr!=0.
  - pending[a] is cleared at the edge ending a cycle with rf_we=1 and rf_a3=a, i.e. when the write actually commits.
  - Set and clear of the same address in the same cycle: set wins, because the newer reservation must survive.
  - Reserving an already-pending register (WAW): the bit stays 1; the first write to that register clears it.
- hazard = (rd_a1!=0 && pending[rd_a1]) || (rd_a2!=0 && pending[rd_a2]).
  - No bypass: hazard is still 1 in the cycle where rf_we is writing that register.
- Reset mid-operation: in-flight writes are dropped, the scoreboard clears, and the pointer returns to its reset value.

Decomposition:
- Package rf_ctrl_pkg:
  - AW/DW/IW/NREGS defaults.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef wb_src_e {SRC_ALU, SRC_IMM}.
  - Constant ZERO_REG = '0.
- One sub-module, rr_arbiter2: two-requester round-robin arbiter holding the last pointer, with its own clk/rst. The scoreboard and output registers stay in the top module.

Test Plan:
1. Reset: hold rst=0 with random inputs, then release -> rf_we=0, pending=8'h00, hazard=0; first conflict grants ALU.
2. ALU only: alu_req=1, alu_addr=3, alu_data=32'hDEADBEEF in cycle n -> alu_gnt=1 in n; rf_we=1, rf_a3=3, rf_wd=32'hDEADBEEF in n+1; rf_we=0 in n+2.
3. Conflict: both req held, alu_addr=1, imm_addr=2, imm_data=8'hA5 -> grants ALU, IMM, ALU on consecutive cycles. Writes to r1 then r2 with rf_wd=32'h000000A5; no channel waits more than 1 cycle.
4. Scoreboard RAW:
   - rsv_valid, rsv_addr=5 in cycle n; rd_a1=5 from n+1 -> hazard=1, pending=8'h20.
   - Grant r5 write in m -> hazard still 1 in m+1, 0 in m+2.
5. Simultaneous set/clear: rf_we=1, rf_a3=4 and rsv_valid, rsv_addr=4 in the same cycle -> pending[4] stays 1.
6. Register 0:
   - imm_req, imm_addr=0 -> imm_gnt=1, rf_we stays 0.
   - rsv_addr=0 -> pending stays 0; rd_a1=rd_a2=0 -> hazard=0.
   - Assert rst=0 mid-conflict -> outputs return to reset values at once.

Source files
------------

// File: rtl/rf_writeback_ctrl_pkg.sv
// rtl/rf_writeback_ctrl_pkg.sv - shared sizes and types for the register-file writeback controller
package rf_ctrl_pkg;

  localparam int AW    = 3;
  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int NREGS = 8;

  typedef logic [AW-1:0] reg_addr_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_IMM = 1'b1
  } wb_src_e;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// rtl/rf_writeback_ctrl_if.sv - ALU and immediate writeback request channels
interface rf_writeback_ctrl_if #(
  parameter int AW = rf_ctrl_pkg::AW,
  parameter int DW = rf_ctrl_pkg::DW,
  parameter int IW = rf_ctrl_pkg::IW
);

  logic          alu_req;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          alu_gnt;

  logic          imm_req;
  logic [AW-1:0] imm_addr;
  logic [IW-1:0] imm_data;
  logic          imm_gnt;

  modport master (
    output alu_req, alu_addr, alu_data,
    input  alu_gnt,
    output imm_req, imm_addr, imm_data,
    input  imm_gnt
  );

  modport slave (
    input  alu_req, alu_addr, alu_data,
    output alu_gnt,
    input  imm_req, imm_addr, imm_data,
    output imm_gnt
  );

endinterface

// File: rtl/rf_writeback_ctrl_rr_arbiter2.sv
// rtl/rf_writeback_ctrl_rr_arbiter2.sv - two-requester round-robin arbiter with last-grant pointer
module rr_arbiter2
  import rf_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu,
  input  logic req_imm,
  output logic gnt_alu,
  output logic gnt_imm
);

  wb_src_e last_q, last_d;

  // Reset to IMM so the ALU wins the first conflict.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= SRC_IMM;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    gnt_alu = 1'b0;
    gnt_imm = 1'b0;
    last_d  = last_q;

    if (req_alu && req_imm) begin
      if (last_q == SRC_IMM) begin
        gnt_alu = 1'b1;
      end else begin
        gnt_imm = 1'b1;
      end
    end else if (req_alu) begin
      gnt_alu = 1'b1;
    end else if (req_imm) begin
      gnt_imm = 1'b1;
    end

    if (gnt_alu) begin
      last_d = SRC_ALU;
    end else if (gnt_imm) begin
      last_d = SRC_IMM;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - register-file write-port controller with pending-write scoreboard
module rf_writeback_ctrl #(
  parameter int NREGS = rf_ctrl_pkg::NREGS,
  parameter int AW    = rf_ctrl_pkg::AW,
  parameter int DW    = rf_ctrl_pkg::DW,
  parameter int IW    = rf_ctrl_pkg::IW
) (
  input  logic             clk,
  input  logic             rst,
  rf_writeback_ctrl_if.slave wb,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic [AW-1:0]    rd_a1,
  input  logic [AW-1:0]    rd_a2,
  output logic             hazard,
  output logic             rf_we,
  output logic [AW-1:0]    rf_a3,
  output logic [DW-1:0]    rf_wd,
  output logic [NREGS-1:0] pending
);

  import rf_ctrl_pkg::*;

  logic             alu_gnt;
  logic             imm_gnt;
  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_data;
  logic             launch;
  logic [NREGS-1:0] pending_d;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_alu (wb.alu_req),
    .req_imm (wb.imm_req),
    .gnt_alu (alu_gnt),
    .gnt_imm (imm_gnt)
  );

  assign wb.alu_gnt = alu_gnt;
  assign wb.imm_gnt = imm_gnt;

  always_comb begin
    win_addr = wb.imm_addr;
    win_data = DW'(wb.imm_data);
    if (alu_gnt) begin
      win_addr = wb.alu_addr;
      win_data = wb.alu_data;
    end
  end

  // Writes to r0 are granted and consumed but never reach the file.
  assign launch = (alu_gnt || imm_gnt) && (win_addr != ZERO_REG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= launch;
      if (launch) begin
        rf_a3 <= win_addr;
        rf_wd <= win_data;
      end
    end
  end

  // Clear on commit first, then set, so a same-cycle reservation survives.
  always_comb begin
    pending_d = pending;
    if (rf_we) begin
      pending_d[rf_a3] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != ZERO_REG)) begin
      pending_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

  assign hazard = ((rd_a1 != ZERO_REG) && pending[rd_a1]) ||
                  ((rd_a2 != ZERO_REG) && pending[rd_a2]);

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - self-checking bench for rf_writeback_ctrl
`timescale 1ns/1ps
module tb_rf_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rsv_valid;
  logic [2:0]  rsv_addr, rd_a1, rd_a2;
  logic        hazard, rf_we;
  logic [2:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [7:0]  pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rf_writeback_ctrl_if wb ();

  rf_writeback_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rd_a1     (rd_a1),
    .rd_a2     (rd_a2),
    .hazard    (hazard),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd),
    .pending   (pending)
  );

  typedef struct {
    logic        ar;  logic [2:0] aa; logic [31:0] ad;
    logic        ir;  logic [2:0] ia; logic [7:0]  id;
    logic        rv;  logic [2:0] ra; logic [2:0]  r1; logic [2:0] r2;
    logic        ega; logic egi; logic ehaz; logic ewe;
    logic [2:0]  ea3; logic [31:0] ewd; logic [7:0] epend;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic ar, input logic [2:0] aa, input logic [31:0] ad,
                        input logic ir, input logic [2:0] ia, input logic [7:0] id,
                        input logic rv, input logic [2:0] ra,
                        input logic [2:0] r1, input logic [2:0] r2);
    wb.alu_req = ar; wb.alu_addr = aa; wb.alu_data = ad;
    wb.imm_req = ir; wb.imm_addr = ia; wb.imm_data = id;
    rsv_valid = rv; rsv_addr = ra; rd_a1 = r1; rd_a2 = r2;
  endtask

  task automatic add(input logic ar, input logic [2:0] aa, input logic [31:0] ad,
                     input logic ir, input logic [2:0] ia, input logic [7:0] id,
                     input logic rv, input logic [2:0] ra, input logic [2:0] r1, input logic [2:0] r2,
                     input logic ega, input logic egi, input logic ehaz, input logic ewe,
                     input logic [2:0] ea3, input logic [31:0] ewd, input logic [7:0] epend);
    vec_t v;
    v.ar = ar; v.aa = aa; v.ad = ad; v.ir = ir; v.ia = ia; v.id = id;
    v.rv = rv; v.ra = ra; v.r1 = r1; v.r2 = r2;
    v.ega = ega; v.egi = egi; v.ehaz = ehaz; v.ewe = ewe;
    v.ea3 = ea3; v.ewd = ewd; v.epend = epend;
    tbl.push_back(v);
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  // Reference model: last-grant flag, per-register pending bits, one pending launch.
  bit          m_last_imm;
  bit          m_pend[8];
  bit          m_we;
  logic [2:0]  m_a3;
  logic [31:0] m_wd;

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = m_pend[k];
    return r;
  endfunction

  initial begin
    logic ar, ir, rv, ega, egi, ehaz, hold_a, hold_i;
    logic [2:0] aa, ia, ra, r1, r2, waddr;
    logic [31:0] ad;
    logic [7:0] id;

    // Reset held with random inputs.
    idle();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      set_in(1'($urandom), 3'($urandom), $urandom, 1'($urandom), 3'($urandom), 8'($urandom),
             1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
      #3;
      chk("rst_we", 32'(rf_we), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_a3", 32'(rf_a3), 32'd0);
      chk("rst_wd", rf_wd, 32'd0);
    end
    @(posedge clk); #1;
    idle();
    rst = 1'b1;

    //   ar   aa    ad            ir   ia    id     rv   ra    r1    r2    ega  egi  haz  we   a3    wd            pend
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd0,32'h0,        8'h00);
    add(1'b1,3'd1,32'h11111111, 1'b1,3'd2,8'hA5, 1'b0,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b0,1'b0,3'd0,32'h0,        8'h00);
    add(1'b1,3'd1,32'h11111111, 1'b1,3'd2,8'hA5, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b0,1'b1,3'd1,32'h11111111, 8'h00);
    add(1'b1,3'd1,32'h11111111, 1'b1,3'd2,8'hA5, 1'b0,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b0,1'b1,3'd2,32'h000000A5, 8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b1,3'd1,32'h11111111, 8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd1,32'h11111111, 8'h00);
    add(1'b1,3'd3,32'hDEADBEEF, 1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b0,1'b0,3'd1,32'h11111111, 8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b1,3'd3,32'hDEADBEEF, 8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd3,32'hDEADBEEF, 8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b1,3'd5,3'd5,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd3,32'hDEADBEEF, 8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd5,3'd0, 1'b0,1'b0,1'b1,1'b0,3'd3,32'hDEADBEEF, 8'h20);
    add(1'b1,3'd5,32'h55,       1'b0,3'd0,8'h00, 1'b0,3'd0,3'd5,3'd0, 1'b1,1'b0,1'b1,1'b0,3'd3,32'hDEADBEEF, 8'h20);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd5,3'd0, 1'b0,1'b0,1'b1,1'b1,3'd5,32'h55,       8'h20);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd5,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd5,32'h55,       8'h00);
    add(1'b1,3'd4,32'h44,       1'b0,3'd0,8'h00, 1'b1,3'd4,3'd0,3'd4, 1'b1,1'b0,1'b0,1'b0,3'd5,32'h55,       8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b1,3'd4,3'd0,3'd4, 1'b0,1'b0,1'b1,1'b1,3'd4,32'h44,       8'h10);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd4, 1'b0,1'b0,1'b1,1'b0,3'd4,32'h44,       8'h10);
    add(1'b1,3'd4,32'h99,       1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd4, 1'b1,1'b0,1'b1,1'b0,3'd4,32'h44,       8'h10);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd4, 1'b0,1'b0,1'b1,1'b1,3'd4,32'h99,       8'h10);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd4, 1'b0,1'b0,1'b0,1'b0,3'd4,32'h99,       8'h00);
    add(1'b0,3'd0,32'h0,        1'b1,3'd0,8'h7E, 1'b1,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b0,1'b0,3'd4,32'h99,       8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd4,32'h99,       8'h00);
    add(1'b1,3'd6,32'h66,       1'b1,3'd7,8'h77, 1'b0,3'd0,3'd0,3'd0, 1'b1,1'b0,1'b0,1'b0,3'd4,32'h99,       8'h00);
    add(1'b1,3'd6,32'h66,       1'b1,3'd7,8'h77, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b1,1'b0,1'b1,3'd6,32'h66,       8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b1,3'd7,32'h77,       8'h00);
    add(1'b0,3'd0,32'h0,        1'b0,3'd0,8'h00, 1'b0,3'd0,3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,3'd7,32'h77,       8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].ar, tbl[i].aa, tbl[i].ad, tbl[i].ir, tbl[i].ia, tbl[i].id,
             tbl[i].rv, tbl[i].ra, tbl[i].r1, tbl[i].r2);
      #3;
      chk($sformatf("v%0d_alu_gnt", i), 32'(wb.alu_gnt), 32'(tbl[i].ega));
      chk($sformatf("v%0d_imm_gnt", i), 32'(wb.imm_gnt), 32'(tbl[i].egi));
      chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(tbl[i].ehaz));
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(tbl[i].ewe));
      chk($sformatf("v%0d_rf_a3", i), 32'(rf_a3), 32'(tbl[i].ea3));
      chk($sformatf("v%0d_rf_wd", i), rf_wd, tbl[i].ewd);
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'(tbl[i].epend));
      @(posedge clk); #1;
    end

    // Reset asserted mid-conflict: pointer was ALU, r3 reserved, r1 write in flight.
    set_in(1'b1, 3'd1, 32'hAAAA0001, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd3, 3'd0);
    #3;
    chk("mr_a_alu_gnt", 32'(wb.alu_gnt), 32'd1);
    @(posedge clk); #1;
    set_in(1'b1, 3'd1, 32'hAAAA0001, 1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 3'd3, 3'd0);
    #1;
    chk("mr_b_imm_gnt", 32'(wb.imm_gnt), 32'd1);
    chk("mr_b_rf_we", 32'(rf_we), 32'd1);
    chk("mr_b_pending", 32'(pending), 32'h08);
    chk("mr_b_hazard", 32'(hazard), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mr_rst_rf_we", 32'(rf_we), 32'd0);
    chk("mr_rst_rf_a3", 32'(rf_a3), 32'd0);
    chk("mr_rst_rf_wd", rf_wd, 32'd0);
    chk("mr_rst_pending", 32'(pending), 32'd0);
    chk("mr_rst_hazard", 32'(hazard), 32'd0);
    chk("mr_rst_alu_gnt", 32'(wb.alu_gnt), 32'd1);
    chk("mr_rst_imm_gnt", 32'(wb.imm_gnt), 32'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_post_rf_we", 32'(rf_we), 32'd1);
    chk("mr_post_rf_a3", 32'(rf_a3), 32'd1);
    chk("mr_post_rf_wd", rf_wd, 32'hAAAA0001);
    chk("mr_post_imm_gnt", 32'(wb.imm_gnt), 32'd1);
    idle();

    // Randomized run against the model, starting from a fresh reset.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    m_last_imm = 1'b1;
    for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
    m_we = 1'b0; m_a3 = 3'd0; m_wd = 32'd0;
    hold_a = 1'b0; hold_i = 1'b0;
    ar = 1'b0; aa = 3'd0; ad = 32'd0; ir = 1'b0; ia = 3'd0; id = 8'd0;

    for (int c = 0; c < 400; c++) begin
      if (!hold_a) begin
        ar = 1'($urandom_range(0, 1)); aa = 3'($urandom_range(0, 7)); ad = $urandom;
      end
      if (!hold_i) begin
        ir = 1'($urandom_range(0, 1)); ia = 3'($urandom_range(0, 7)); id = 8'($urandom);
      end
      rv = ($urandom_range(0, 2) == 0);
      ra = 3'($urandom_range(0, 7));
      r1 = 3'($urandom_range(0, 7));
      r2 = 3'($urandom_range(0, 7));
      set_in(ar, aa, ad, ir, ia, id, rv, ra, r1, r2);
      #3;

      if (ar && ir) begin
        ega = m_last_imm; egi = !m_last_imm;
      end else begin
        ega = ar; egi = ir;
      end
      ehaz = ((r1 != 3'd0) && m_pend[r1]) || ((r2 != 3'd0) && m_pend[r2]);

      chk("rnd_alu_gnt", 32'(wb.alu_gnt), 32'(ega));
      chk("rnd_imm_gnt", 32'(wb.imm_gnt), 32'(egi));
      chk("rnd_hazard", 32'(hazard), 32'(ehaz));
      chk("rnd_rf_we", 32'(rf_we), 32'(m_we));
      chk("rnd_rf_a3", 32'(rf_a3), 32'(m_a3));
      chk("rnd_rf_wd", rf_wd, m_wd);
      chk("rnd_pending", 32'(pending), 32'(m_pend_vec()));

      if (m_we) m_pend[m_a3] = 1'b0;
      if (rv && ra != 3'd0) m_pend[ra] = 1'b1;
      if (ega || egi) begin
        m_last_imm = egi;
        waddr = ega ? aa : ia;
        if (waddr != 3'd0) begin
          m_we = 1'b1;
          m_a3 = waddr;
          m_wd = ega ? ad : {24'd0, id};
        end else begin
          m_we = 1'b0;
        end
      end else begin
        m_we = 1'b0;
      end
      hold_a = ar && !ega;
      hold_i = ir && !egi;

      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
